// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and helpers for the elastic pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int MAX_PIPE_DEPTH = 16;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/elastic_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_if
// Description : Valid/ready stream bundle with flush and occupancy report.
// Revision    : 1.0 - initial release
// ============================================================================
interface elastic_pipe_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic                         flush;
    logic                         in_valid;
    logic [WIDTH-1:0]             in_data;
    logic                         in_ready;
    logic                         out_valid;
    logic [WIDTH-1:0]             out_data;
    logic                         out_ready;
    logic [occ_width(DEPTH)-1:0]  occupancy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface : elastic_pipe_if
`default_nettype wire

// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : One pipeline register with a valid bit; data loads only with
//               a valid word so bubbles never overwrite held data.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic             i_valid,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic      [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule : pipe_stage
`default_nettype wire

// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe
// Description : DEPTH-stage valid/ready register pipeline with bubble
//               collapse, synchronous flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    elastic_pipe_if.slave bus
);
    localparam int c_OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_en;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic [c_OCC_W-1:0] w_occ;

    if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_depth_check
        $error("elastic_pipe: DEPTH out of range");
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_vin;
        logic [WIDTH-1:0] w_din;

        if (i == 0) begin : g_head
            assign w_vin = bus.in_valid;
            assign w_din = bus.in_data;
        end else begin : g_body
            assign w_vin = w_v[i-1];
            assign w_din = w_d[i-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (bus.flush),
            .i_en    (w_en[i]),
            .i_valid (w_vin),
            .i_data  (w_din),
            .o_valid (w_v[i]),
            .o_data  (w_d[i])
        );
    end

    // Enable ripples from the output side: a stage may move if it is empty
    // or everything downstream of it is moving.
    always_comb begin
        logic w_run;
        w_en  = '0;
        w_run = ~w_v[DEPTH-1] | bus.out_ready;
        w_en[DEPTH-1] = w_run;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_run   = ~w_v[i] | w_run;
            w_en[i] = w_run;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + c_OCC_W'(w_v[i]);
        end
    end

    assign bus.in_ready  = w_en[0] & ~bus.flush;
    assign bus.out_valid = w_v[DEPTH-1];
    assign bus.out_data  = w_d[DEPTH-1];
    assign bus.occupancy = w_occ;
endmodule : elastic_pipe
`default_nettype wire

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised multi-stage register pipeline. It generalises the single synchronous-reset D flip-flop to WIDTH bits × DEPTH stages.
- Each stage carries a valid bit. Valid/ready backpressure lets stalled data hold in place while bubbles collapse.
- Used to retime long datapaths between design units without losing or duplicating words.
- Also provides a synchronous flush and an occupancy count.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 3, number of register stages; legal range 1..16.
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  pipe accepts in_data this cycle.
- out_valid  output  1  stage DEPTH-1 holds a word.
- out_data  output  WIDTH  contents of stage DEPTH-1.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): data[i] (WIDTH bits) and v[i] (1 bit).
- Reset (rst=1 at posedge): all v[i]=0 and all data[i]=RESET_VAL.
  - After reset: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 (unless flush is high).
  - rst overrides flush and all handshakes.
- Stage advance enable, combinational from the output side backwards:
  - en[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - en[i] = !v[i] | en[i+1].
  - in_ready = en[0] & !flush.
- On posedge, when not rst and not flush:
  - Stage 0 with en[0]: v[0] <= in_valid; data[0] <= in_data only if in_valid.
  - Stage i>0 with en[i]: v[i] <= v[i-1]; data[i] <= data[i-1] only if v[i-1].
  - A stage whose en is 0 holds data and v unchanged.
  - Data registers load only on valid transfer. Bubbles never overwrite held data, so out_data is stable while out_valid & !out_ready.
- Handshakes:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - No word is dropped, duplicated or reordered.
- Latency: an accepted word appears at out_valid exactly DEPTH cycles after acceptance when no stall occurs.
- Throughput: 1 word/cycle sustained when out_ready is held 1.
- Bubble collapse: an invalid stage accepts from upstream even when downstream is stalled.
  - With out_ready=0 the pipe fills to DEPTH words.
  - in_ready falls only when every stage is valid and out_ready=0.
- Full pipe with out_ready=1: input and output transfers occur in the same cycle; occupancy is unchanged.
- flush=1 at posedge:
  - All v[i] <= 0.
  - Data registers are unchanged.
  - in_ready=0 during flush, so no input transfer occurs.
  - An output transfer may still be signalled in that cycle; the word is consumed and the stage is cleared anyway.
- occupancy: combinational popcount of v[].
  - Range 0..DEPTH; never exceeds DEPTH.
  - Reflects the registered state, not the current-cycle transfers.
- Reset mid-operation: every in-flight word is discarded. The next cycle behaves as after power-on reset.
- in_valid is treated as 0 during rst (in_ready is irrelevant).

Decomposition:
- Shared package, a pipeline definitions package (pipe_pkg): MAX_PIPE_DEPTH=16 and a function for the occupancy width (clog2 of DEPTH+1).
- One natural sub-module, pipe_stage: a single WIDTH-bit register plus valid bit with en/load inputs and synchronous rst.
  - elastic_pipe instantiates DEPTH copies of it in a generate loop and computes the en chain and popcount.

Test Plan:
1. Reset: assert rst 2 cycles with in_valid=1, in_data=0xAA → out_valid=0, out_data=RESET_VAL (0x00), occupancy=0, in_ready=1 after release.
2. Streaming, DEPTH=3, out_ready=1: send 0x01..0x05 on consecutive cycles → out_valid rises 3 cycles after the first accept; outputs 0x01..0x05 in order, one per cycle, no gaps.
3. Backpressure fill: out_ready=0, send 0x10,0x11,0x12,0x13 → first 3 accepted, in_ready=0 on the 4th, occupancy=3, out_data held at 0x10. Then out_ready=1 → 0x10,0x11,0x12,0x13 delivered with 0x13 accepted the cycle after release.
4. Bubble collapse: send 0x20, idle 2 cycles, send 0x21 with out_ready=0 → both packed into stages 2 and 1, occupancy=2, no loss.
5. Flush: pipe holding 0x30,0x31 with in_valid=1, in_data=0x32, flush=1 → in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; 0x32 never appears.
6. Mid-stream reset: during test 2 assert rst for one cycle → all valid bits cleared, out_data=0x00. Subsequent words 0x40,0x41 emerge with latency 3 and nothing stale.
